tank_render_multi: RTL

TANK_RENDER_MULTI -- requirements
Module: tank_render_multi

---
 rtl/tank_pkg.sv | 29 ++
 rtl/tank_chan.sv | 155 +++++++++++++++
 rtl/tank_render_multi.sv | 83 ++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared constants and types for the tank renderer: colours, direction codes and channel states.
package tank_pkg;

    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] YELLOW = 12'hFF0;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALIVE   = 2'd1,
        ST_EXPLODE = 2'd2,
        ST_DEAD    = 2'd3
    } chan_state_t;

    function automatic logic in_range(input logic signed [11:0] v,
                                      input logic signed [11:0] lo,
                                      input logic signed [11:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/tank_chan.sv
// One tank channel: lifecycle FSM, explosion counter, stage-1 offset registers and the shape test.
module tank_chan
    import tank_pkg::*;
#(
    parameter int CELL        = 20,
    parameter int X_OFF       = 160,
    parameter int Y_OFF       = 40,
    parameter int EXPL_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [10:0] VGA_xpos,
    input  logic [10:0] VGA_ypos,
    input  logic [4:0]  x_rel_pos,
    input  logic [4:0]  y_rel_pos,
    input  logic        tank_state,
    input  logic        tank_ide,
    input  logic [1:0]  tank_dir,
    input  logic        tank_hit,
    output logic        hit,
    output logic [11:0] colour,
    output logic        expl_busy
);

    // Counter is at least 4 bits so the radius/colour taps cnt[3:1] always exist.
    localparam int CW = (EXPL_FRAMES > 16) ? $clog2(EXPL_FRAMES) : 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXPL_FRAMES - 1);

    chan_state_t        state_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;

    logic [11:0]        cx_s, cy_s;
    logic signed [11:0] dx_s, dy_s;

    logic signed [11:0] dx_r, dy_r;
    chan_state_t        st1_r;
    logic [2:0]         cnt1_r;
    logic               ide1_r;
    logic [1:0]         dir1_r;

    logic signed [11:0] rad_raw_s, rad_s;
    logic               body_s, barrel_s;

    assign cx_s = 12'(X_OFF) + 12'(x_rel_pos) * 12'(CELL);
    assign cy_s = 12'(Y_OFF) + 12'(y_rel_pos) * 12'(CELL);
    assign dx_s = $signed({1'b0, VGA_xpos} - cx_s);
    assign dy_s = $signed({1'b0, VGA_ypos} - cy_s);

    // Channel lifecycle; tank_state=0 wins over everything, including a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else if (!tank_state) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_ALIVE;
                end
                ST_ALIVE: begin
                    if (tank_hit) begin
                        state_r <= ST_EXPLODE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_ALIVE;
                    end
                end
                ST_EXPLODE: begin
                    if (frame_start && (cnt_r == CNT_LAST)) begin
                        state_r <= ST_DEAD;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else if (frame_start) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DEAD: begin
                    state_r <= ST_DEAD;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: pixel offsets together with the state snapshot they are drawn against.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_r   <= 12'sd0;
            dy_r   <= 12'sd0;
            st1_r  <= ST_IDLE;
            cnt1_r <= 3'd0;
            ide1_r <= 1'b0;
            dir1_r <= 2'b00;
        end else begin
            dx_r   <= dx_s;
            dy_r   <= dy_s;
            st1_r  <= state_r;
            cnt1_r <= cnt_r[3:1];
            ide1_r <= tank_ide;
            dir1_r <= tank_dir;
        end
    end

    assign rad_raw_s = 12'sd2 + $signed({9'd0, cnt1_r});
    assign rad_s     = (rad_raw_s > 12'sd9) ? 12'sd9 : rad_raw_s;
    assign body_s    = in_range(dx_r, -12'sd5, 12'sd5) && in_range(dy_r, -12'sd5, 12'sd5);

    // Barrel: three pixels wide, 6..9 pixels out from the centre along the facing.
    always_comb begin
        barrel_s = 1'b0;
        case (dir1_r)
            DIR_UP:    barrel_s = in_range(dx_r, -12'sd1, 12'sd1) && in_range(dy_r, -12'sd9, -12'sd6);
            DIR_DOWN:  barrel_s = in_range(dx_r, -12'sd1, 12'sd1) && in_range(dy_r, 12'sd6, 12'sd9);
            DIR_LEFT:  barrel_s = in_range(dy_r, -12'sd1, 12'sd1) && in_range(dx_r, -12'sd9, -12'sd6);
            DIR_RIGHT: barrel_s = in_range(dy_r, -12'sd1, 12'sd1) && in_range(dx_r, 12'sd6, 12'sd9);
            default:   barrel_s = 1'b0;
        endcase
    end

    // Shape test and colour for the sampled state.
    always_comb begin
        hit    = 1'b0;
        colour = BLACK;
        case (st1_r)
            ST_ALIVE: begin
                hit    = body_s || barrel_s;
                colour = ide1_r ? BLUE : RED;
            end
            ST_EXPLODE: begin
                hit    = in_range(dx_r, -rad_s, rad_s) && in_range(dy_r, -rad_s, rad_s);
                colour = cnt1_r[0] ? RED : YELLOW;
            end
            default: begin
                hit    = 1'b0;
                colour = BLACK;
            end
        endcase
    end

    assign expl_busy = busy_r;

endmodule

// File: rtl/tank_render_multi.sv
// Multi-tank sprite renderer: N_TANK channels feeding a lowest-index-wins priority encoder,
// with registered VGA outputs two clocks after the pixel coordinates.
module tank_render_multi
    import tank_pkg::*;
#(
    parameter int N_TANK      = 4,
    parameter int CELL        = 20,
    parameter int X_OFF       = 160,
    parameter int Y_OFF       = 40,
    parameter int EXPL_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [10:0]           VGA_xpos,
    input  logic [10:0]           VGA_ypos,
    input  logic [5*N_TANK-1:0]   x_rel_pos,
    input  logic [5*N_TANK-1:0]   y_rel_pos,
    input  logic [N_TANK-1:0]     tank_state,
    input  logic [N_TANK-1:0]     tank_ide,
    input  logic [2*N_TANK-1:0]   tank_dir,
    input  logic [N_TANK-1:0]     tank_hit,
    output logic [11:0]           VGA_data,
    output logic                  VGA_en,
    output logic [N_TANK-1:0]     expl_busy
);

    logic [N_TANK-1:0] hit_s;
    logic [11:0]       colour_s [N_TANK];
    logic [11:0]       sel_data_s;
    logic              sel_en_s;
    logic [11:0]       data_r;
    logic              en_r;

    for (genvar i = 0; i < N_TANK; i++) begin : g_chan
        tank_chan #(
            .CELL        (CELL),
            .X_OFF       (X_OFF),
            .Y_OFF       (Y_OFF),
            .EXPL_FRAMES (EXPL_FRAMES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_start (frame_start),
            .VGA_xpos    (VGA_xpos),
            .VGA_ypos    (VGA_ypos),
            .x_rel_pos   (x_rel_pos[5*i +: 5]),
            .y_rel_pos   (y_rel_pos[5*i +: 5]),
            .tank_state  (tank_state[i]),
            .tank_ide    (tank_ide[i]),
            .tank_dir    (tank_dir[2*i +: 2]),
            .tank_hit    (tank_hit[i]),
            .hit         (hit_s[i]),
            .colour      (colour_s[i]),
            .expl_busy   (expl_busy[i])
        );
    end

    // Priority encoder: the first hitting channel claims the pixel.
    always_comb begin
        sel_en_s   = 1'b0;
        sel_data_s = BLACK;
        for (int i = 0; i < N_TANK; i++) begin
            sel_data_s = (hit_s[i] && !sel_en_s) ? colour_s[i] : sel_data_s;
            sel_en_s   = sel_en_s | hit_s[i];
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= BLACK;
            en_r   <= 1'b0;
        end else begin
            data_r <= sel_data_s;
            en_r   <= sel_en_s;
        end
    end

    assign VGA_data = data_r;
    assign VGA_en   = en_r;

endmodule
